// File: rtl/serial_audio_format_controller_if.sv
// Control/data bundle between the format controller, its serial audio decoder and the downstream frame sink.
// master = controller view, slave = decoder/sink/host view.
interface serial_audio_format_controller_if #(
  parameter int unsigned AUDIO_WIDTH = 32
);
  logic                   enable;
  logic                   dec_reset;
  logic                   dec_is_i2s;
  logic                   dec_lrclk_polarity;
  logic                   dec_is_error;
  logic                   dec_valid;
  logic                   dec_ready;
  logic                   dec_is_left;
  logic [AUDIO_WIDTH-1:0] dec_audio;
  logic                   o_valid;
  logic                   o_ready;
  logic [AUDIO_WIDTH-1:0] o_left;
  logic [AUDIO_WIDTH-1:0] o_right;
  logic                   locked;
  logic [1:0]             format;

  modport master (
    input  enable, dec_is_error, dec_valid, dec_is_left, dec_audio, o_ready,
    output dec_reset, dec_is_i2s, dec_lrclk_polarity, dec_ready,
           o_valid, o_left, o_right, locked, format
  );

  modport slave (
    output enable, dec_is_error, dec_valid, dec_is_left, dec_audio, o_ready,
    input  dec_reset, dec_is_i2s, dec_lrclk_polarity, dec_ready,
           o_valid, o_left, o_right, locked, format
  );
endinterface

// File: rtl/serial_audio_format_controller.sv
// Auto-detects the serial audio format of one decoder by cycling format candidates, then pairs
// left/right samples into stereo frames behind a one-frame valid/ready output buffer.
module serial_audio_format_controller #(
  parameter int unsigned AUDIO_WIDTH    = 32,
  parameter int unsigned LOCK_FRAMES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  serial_audio_format_controller_if.master bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_SEARCH, S_LOCKED} state_t;

  state_t                 state;
  logic                   rst_cnt;
  logic [TMO_W-1:0]       tmo;
  logic [CNT_W-1:0]       pair_cnt;
  logic                   left_pend;
  logic [AUDIO_WIDTH-1:0] left_hold;
  logic                   dec_reset_q;
  logic                   o_valid_q;
  logic [AUDIO_WIDTH-1:0] o_left_q;
  logic [AUDIO_WIDTH-1:0] o_right_q;
  logic                   locked_q;
  logic [1:0]             format_q;

  logic dec_ready_c;
  logic xfer;
  logic tmo_hit;

  // Accept samples freely while searching; when locked only if the output slot frees this cycle.
  always_comb begin
    dec_ready_c = 1'b0;
    if (state == S_SEARCH)
      dec_ready_c = 1'b1;
    else if (state == S_LOCKED)
      dec_ready_c = !(o_valid_q && !bus.o_ready);
  end

  assign xfer    = bus.dec_valid && dec_ready_c;
  assign tmo_hit = (tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rst_cnt     <= 1'b0;
      tmo         <= '0;
      pair_cnt    <= '0;
      left_pend   <= 1'b0;
      left_hold   <= '0;
      dec_reset_q <= 1'b1;
      o_valid_q   <= 1'b0;
      o_left_q    <= '0;
      o_right_q   <= '0;
      locked_q    <= 1'b0;
      format_q    <= 2'd0;
    end else begin
      // A held frame drains on handshake in every enabled state; a same-cycle load below wins.
      if (o_valid_q && bus.o_ready)
        o_valid_q <= 1'b0;

      if (!bus.enable) begin
        state       <= S_IDLE;
        dec_reset_q <= 1'b1;
        o_valid_q   <= 1'b0;
        locked_q    <= 1'b0;
        left_pend   <= 1'b0;
        pair_cnt    <= '0;
        tmo         <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_RST;
            rst_cnt   <= 1'b0;
            tmo       <= '0;
            pair_cnt  <= '0;
            left_pend <= 1'b0;
          end

          S_RST: begin
            tmo       <= '0;
            pair_cnt  <= '0;
            left_pend <= 1'b0;
            if (rst_cnt) begin
              state       <= S_SEARCH;
              dec_reset_q <= 1'b0;
            end else begin
              rst_cnt <= 1'b1;
            end
          end

          S_SEARCH: begin
            if (bus.dec_is_error || (!xfer && tmo_hit)) begin
              format_q    <= format_q + 2'd1;
              state       <= S_RST;
              rst_cnt     <= 1'b0;
              dec_reset_q <= 1'b1;
            end else if (xfer) begin
              tmo <= '0;
              if (bus.dec_is_left) begin
                if (left_pend)
                  pair_cnt <= '0;
                left_pend <= 1'b1;
              end else if (left_pend) begin
                left_pend <= 1'b0;
                if (pair_cnt == LOCK_LAST) begin
                  state    <= S_LOCKED;
                  locked_q <= 1'b1;
                  pair_cnt <= '0;
                end else begin
                  pair_cnt <= pair_cnt + CNT_W'(1);
                end
              end else begin
                pair_cnt <= '0;
              end
            end else begin
              tmo <= tmo + TMO_W'(1);
            end
          end

          S_LOCKED: begin
            if (bus.dec_is_error || (!xfer && tmo_hit)) begin
              locked_q    <= 1'b0;
              state       <= S_RST;
              rst_cnt     <= 1'b0;
              dec_reset_q <= 1'b1;
            end else if (xfer) begin
              tmo <= '0;
              if (bus.dec_is_left) begin
                left_hold <= bus.dec_audio;
                left_pend <= 1'b1;
              end else if (left_pend) begin
                o_left_q  <= left_hold;
                o_right_q <= bus.dec_audio;
                o_valid_q <= 1'b1;
                left_pend <= 1'b0;
              end
            end else begin
              tmo <= tmo + TMO_W'(1);
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dec_reset          = dec_reset_q;
  assign bus.dec_is_i2s         = format_q[1];
  assign bus.dec_lrclk_polarity = format_q[0];
  assign bus.dec_ready          = dec_ready_c;
  assign bus.o_valid            = o_valid_q;
  assign bus.o_left             = o_left_q;
  assign bus.o_right            = o_right_q;
  assign bus.locked             = locked_q;
  assign bus.format             = format_q;

endmodule

// File: tb/tb_serial_audio_format_controller.sv
// Directed self-checking bench for serial_audio_format_controller (short timeout for fast runs).
module tb_serial_audio_format_controller;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  serial_audio_format_controller_if #(.AUDIO_WIDTH(AW)) bus ();

  serial_audio_format_controller #(
    .AUDIO_WIDTH    (AW),
    .LOCK_FRAMES    (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One decoder sample; returns at the falling edge after the transfer edge.
  task automatic xfer(input logic left, input logic [31:0] data);
    int n;
    n = 0;
    bus.dec_valid   = 1'b1;
    bus.dec_is_left = left;
    bus.dec_audio   = data;
    #1;
    while (!bus.dec_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("dec_ready_for_xfer", 32'(bus.dec_ready), 32'd1);
    @(negedge clk);
    bus.dec_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    xfer(1'b1, l);
    xfer(1'b0, r);
  endtask

  // Counts falling edges with dec_reset high, starting at the current one.
  task automatic pulse_len(output int n);
    n = 0;
    while (bus.dec_reset && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic error_step(input logic [1:0] exp_fmt);
    int n;
    bus.dec_is_error = 1'b1;
    @(negedge clk);
    bus.dec_is_error = 1'b0;
    pulse_len(n);
    check("err_pulse_len", 32'(n), 32'd2);
    check("err_format", 32'(bus.format), 32'(exp_fmt));
    check("err_dec_fmt", 32'({bus.dec_is_i2s, bus.dec_lrclk_polarity}), 32'(exp_fmt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.dec_is_error = 1'b0;
    bus.dec_valid    = 1'b0;
    bus.dec_is_left  = 1'b0;
    bus.dec_audio    = '0;
    bus.o_ready      = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_dec_reset", 32'(bus.dec_reset), 32'd1);
    check("rst_format", 32'(bus.format), 32'd0);
    check("rst_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_o_left", bus.o_left, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Lock on format 0
    bus.enable = 1'b1;
    @(negedge clk);
    pulse_len(n);
    check("en_pulse_len", 32'(n), 32'd2);
    for (int i = 0; i < 3; i++) send_pair(32'h100 + 32'(i), 32'h200 + 32'(i));
    check("lock_after3", 32'(bus.locked), 32'd0);
    send_pair(32'h103, 32'h203);
    check("lock_after4", 32'(bus.locked), 32'd1);
    check("lock_format", 32'(bus.format), 32'd0);
    check("lock_no_dec_reset", 32'(bus.dec_reset), 32'd0);

    // Streaming, frame held under backpressure
    bus.o_ready = 1'b0;
    send_pair(32'h2EEF0000, 32'h33330000);
    check("stream_valid", 32'(bus.o_valid), 32'd1);
    check("stream_left", bus.o_left, 32'h2EEF0000);
    check("stream_right", bus.o_right, 32'h33330000);
    repeat (3) @(negedge clk);
    check("bp_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("bp_valid_held", 32'(bus.o_valid), 32'd1);
    check("bp_left_stable", bus.o_left, 32'h2EEF0000);
    check("bp_right_stable", bus.o_right, 32'h33330000);
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("bp_accepted", 32'(bus.o_valid), 32'd0);
    send_pair(32'h11111111, 32'h22222222);
    check("bp_next_valid", 32'(bus.o_valid), 32'd1);
    check("bp_next_left", bus.o_left, 32'h11111111);
    check("bp_next_right", bus.o_right, 32'h22222222);

    // Pairing: repeated L replaces, orphan R dropped
    xfer(1'b1, 32'd1);
    xfer(1'b1, 32'd2);
    xfer(1'b0, 32'd3);
    check("pair_valid", 32'(bus.o_valid), 32'd1);
    check("pair_left", bus.o_left, 32'd2);
    check("pair_right", bus.o_right, 32'd3);
    xfer(1'b0, 32'd5);
    check("orphan_no_valid", 32'(bus.o_valid), 32'd0);
    check("orphan_right_kept", bus.o_right, 32'd3);

    // Timeout while locked
    n = 0;
    while (bus.locked && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    pulse_len(n);
    check("tmo_pulse_len", 32'(n), 32'd2);
    check("tmo_format_kept", 32'(bus.format), 32'd0);
    check("tmo_locked", 32'(bus.locked), 32'd0);

    // Format search on errors
    error_step(2'd1);
    error_step(2'd2);
    error_step(2'd3);
    error_step(2'd0);

    // Orphan R in search restarts the pair count
    for (int i = 0; i < 3; i++) send_pair(32'h10, 32'h20);
    xfer(1'b0, 32'h30);
    for (int i = 0; i < 3; i++) send_pair(32'h10, 32'h20);
    check("orphan_search_nolock", 32'(bus.locked), 32'd0);
    send_pair(32'h10, 32'h20);
    check("orphan_search_lock", 32'(bus.locked), 32'd1);

    // Disable mid-frame with a frame held and a left pending
    bus.o_ready = 1'b0;
    send_pair(32'hA, 32'hB);
    check("dis_valid_before", 32'(bus.o_valid), 32'd1);
    bus.o_ready = 1'b1;
    xfer(1'b1, 32'hC);
    bus.o_ready = 1'b0;
    bus.enable  = 1'b0;
    @(negedge clk);
    check("dis_o_valid", 32'(bus.o_valid), 32'd0);
    check("dis_locked", 32'(bus.locked), 32'd0);
    check("dis_dec_reset", 32'(bus.dec_reset), 32'd1);
    check("dis_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("dis_format", 32'(bus.format), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
